rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, meaning the number of consecutive denied long-unit cycles before the pipeline is forced to stall (legal range 1..15).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 pipe_we_i  input  1  the main pipeline writeback stage requests a register file write this cycle.
REQ-005 pipe_waddr_i  input  5  destination register of the pipeline write.
REQ-006 pipe_wdata_i  input  32  pipeline write data (ALU or memory result).
REQ-007 lu_valid_i  input  1  the long-latency unit (mul/div) holds a result.
REQ-008 lu_waddr_i  input  5  destination register of the long-unit result.
REQ-009 lu_wdata_i  input  32  long-unit result data.
REQ-010 lu_ready_o  output  1  the long-unit result is accepted this cycle (combinational).
REQ-011 stall_o  output  1  freezes the writeback stage and all upstream stages this cycle (combinational).
REQ-012 rf_we_o  output  1  register file write enable (registered).
REQ-013 rf_waddr_o  output  5  register file write address (registered).
REQ-014 rf_wdata_o  output  32  register file write data (registered).

Function
REQ-015 The block SHALL hold a starvation counter, cnt, 4 bits wide, that saturates at STARVE_LIMIT.
REQ-016 The forced condition is force = lu_valid_i && (cnt == STARVE_LIMIT).
REQ-017 Grant to the long unit SHALL be gnt_lu = lu_valid_i && (!pipe_we_i || force).
REQ-018 Grant to the pipeline SHALL be gnt_pipe = pipe_we_i && !gnt_lu.
REQ-019 lu_ready_o SHALL equal gnt_lu in the same cycle; the long unit SHALL keep its waddr and wdata stable while lu_valid_i=1 and lu_ready_o=0.
REQ-020 stall_o SHALL equal pipe_we_i && gnt_lu.
- While stall_o=1, the pipeline holds pipe_we_i, pipe_waddr_i and pipe_wdata_i unchanged into the next cycle.
REQ-021 cnt update each rising edge:
- gnt_lu=1: cnt SHALL become 0.
- lu_valid_i=1 and gnt_lu=0: cnt SHALL increment, saturating at STARVE_LIMIT.
- lu_valid_i=0: cnt SHALL become 0.
REQ-022 Each cycle, the granted source's waddr and wdata SHALL be registered into rf_waddr_o and rf_wdata_o, giving one cycle of latency from grant to the register file write.
REQ-023 rf_we_o SHALL be registered as (gnt_lu || gnt_pipe) && (selected waddr != 0).
- A write to x0 is still granted and acknowledged, but SHALL produce rf_we_o=0.
REQ-024 With no grant, rf_we_o SHALL become 0, and rf_waddr_o and rf_wdata_o SHALL hold their previous values.
REQ-025 At most one write SHALL reach the register file per cycle; simultaneous requests are never merged.
REQ-026 WAW ordering between the long unit and the pipeline is guaranteed by issue logic and SHALL NOT be checked here.
- The long unit and the pipeline are never valid for the same waddr in the same cycle.
REQ-027 With STARVE_LIMIT=1, one denied cycle SHALL force a stall on the next cycle.

Reset
REQ-028 While rst_n=0, rf_we_o, rf_waddr_o, rf_wdata_o and cnt SHALL be 0 immediately, independent of clk.
REQ-029 During reset, lu_ready_o and stall_o SHALL follow REQ-017..REQ-020 combinationally. No register write SHALL occur until the first rising edge after rst_n deasserts.
REQ-030 Assertion of reset mid-contention SHALL discard any pending starvation history: cnt becomes 0.
- The long unit re-presents its result after reset, and it is not counted as accepted.

Verification
REQ-031 Pipe only: pipe_we_i=1, waddr=5, wdata=0xDEADBEEF, lu_valid_i=0 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; stall_o=0.
REQ-032 Idle slot: pipe_we_i=0, lu_valid_i=1, waddr=7, wdata=0x12345678 -> lu_ready_o=1 and stall_o=0 that cycle; next cycle rf_we_o=1, rf_waddr_o=7.
REQ-033 Starvation, STARVE_LIMIT=4: pipe_we_i=1 continuously, lu_valid_i=1 from cycle 0 -> pipe wins cycles 0..3. In cycle 4: lu_ready_o=1 and stall_o=1, and the long-unit write appears at cycle 5. The held pipe write is granted in cycle 5 and cnt=0.
REQ-034 x0 write: pipe_we_i=1, waddr=0 -> rf_we_o stays 0 and stall_o=0; with lu_valid_i=1, waddr=0 and an idle pipe -> lu_ready_o=1 and rf_we_o=0.
REQ-035 Reset mid-contention: cnt=3, rst_n pulsed low between edges -> rf_we_o=0 immediately. After release, four further denied cycles are needed before stall_o=1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between the main
// pipeline and a long-latency unit, with bounded starvation of the long unit.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,
  output logic        lu_ready_o,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a long-unit result transfers in any cycle where lu_valid_i and
  // lu_ready_o are both 1; until then the unit holds waddr/wdata stable. A pipe
  // write transfers when pipe_we_i=1 and stall_o=0; while stalled it is held.
  logic [3:0]  cnt;
  logic        force_lu;
  logic        gnt_lu;
  logic        gnt_pipe;
  logic [4:0]  sel_waddr;
  logic [31:0] sel_wdata;

  always_comb begin
    force_lu  = lu_valid_i && (cnt == LIMIT);
    gnt_lu    = lu_valid_i && (!pipe_we_i || force_lu);
    gnt_pipe  = pipe_we_i && !gnt_lu;
    sel_waddr = gnt_lu ? lu_waddr_i : pipe_waddr_i;
    sel_wdata = gnt_lu ? lu_wdata_i : pipe_wdata_i;
  end

  assign lu_ready_o = gnt_lu;
  assign stall_o    = pipe_we_i && gnt_lu;

  // Consecutive cycles the long unit has been denied, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (gnt_lu || !lu_valid_i) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (gnt_lu || gnt_pipe) begin
      // x0 writes are acknowledged but never reach the register file
      rf_we_o    <= (sel_waddr != 5'd0);
      rf_waddr_o <= sel_waddr;
      rf_wdata_o <= sel_wdata;
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus protocol-respecting random
// traffic, checked against a behavioural model of the arbitration rules.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready_o;
  logic        stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_we_i    (pipe_we),
    .pipe_waddr_i (pipe_waddr),
    .pipe_wdata_i (pipe_wdata),
    .lu_valid_i   (lu_valid),
    .lu_waddr_i   (lu_waddr),
    .lu_wdata_i   (lu_wdata),
    .lu_ready_o   (lu_ready_o),
    .stall_o      (stall_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int              n_cmp;
  int              n_bad;
  logic [37:0]     exp_q[$];
  int              streak;
  logic [4:0]      m_addr;
  logic [31:0]     m_data;
  logic            prev_lu_pending;
  logic            prev_stall;

  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    streak          = 0;
    m_addr          = '0;
    m_data          = '0;
    prev_lu_pending = 1'b0;
    prev_stall      = 1'b0;
  endtask

  // One arbitration cycle: inputs already driven just after a falling edge.
  task automatic step();
    logic        lu_win;
    logic [37:0] e;
    #1;
    lu_win = lu_valid && (!pipe_we || streak >= LIMIT);
    check("lu_ready", 38'(lu_ready_o), 38'(lu_win));
    check("stall", 38'(stall_o), 38'(pipe_we && lu_win));
    if (lu_win) begin
      m_addr = lu_waddr;
      m_data = lu_wdata;
      e = {(lu_waddr != 5'd0), lu_waddr, lu_wdata};
    end else if (pipe_we) begin
      m_addr = pipe_waddr;
      m_data = pipe_wdata;
      e = {(pipe_waddr != 5'd0), pipe_waddr, pipe_wdata};
    end else begin
      e = {1'b0, m_addr, m_data};
    end
    exp_q.push_back(e);
    if (lu_win || !lu_valid) streak = 0;
    else if (streak < LIMIT) streak = streak + 1;
    prev_lu_pending = lu_valid && !lu_win;
    prev_stall      = pipe_we && lu_win;
    @(posedge clk);
    @(negedge clk);
    check("rf_write", {rf_we_o, rf_waddr_o, rf_wdata_o}, exp_q.pop_front());
  endtask

  task automatic drive_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_we = we; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v; lu_waddr = a; lu_wdata = d;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    rst_n = 1'b0;
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    #2;
    check("reset_rf", {rf_we_o, rf_waddr_o, rf_wdata_o}, 38'd0);
    drive_lu(1'b1, 5'd3, 32'h1);
    #1;
    check("reset_comb_ready", 38'(lu_ready_o), 38'd1);
    check("reset_comb_stall", 38'(stall_o), 38'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // pipe only
    drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check("pipe_only", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 5'd5, 32'hDEADBEEF});

    // idle slot goes to the long unit
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b1, 5'd7, 32'h12345678);
    step();
    check("idle_slot", {rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b1, 5'd7, 32'h12345678});

    // x0 writes from either source are acknowledged but suppressed
    drive_lu(1'b0, 5'd0, 32'd0);
    drive_pipe(1'b1, 5'd0, 32'hAAAA5555);
    step();
    check("x0_pipe_we", 38'(rf_we_o), 38'd0);
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b1, 5'd0, 32'h5555AAAA);
    step();
    check("x0_lu_we", 38'(rf_we_o), 38'd0);

    // starvation: pipe wins cycles 0..3, long unit forced in cycle 4
    drive_pipe(1'b1, 5'd3, 32'hCAFE0003);
    drive_lu(1'b1, 5'd9, 32'hBEEF0009);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) drive_lu(1'b0, 5'd0, 32'd0);
      #1;
      check("starve_stall", 38'(stall_o), 38'(i == 4));
      check("starve_ready", 38'(lu_ready_o), 38'(i == 4));
      step();
      if (i == 4) check("starve_lu_write", {rf_we_o, rf_waddr_o}, {1'b1, 5'd9});
      if (i == 5) check("starve_pipe_after", {rf_we_o, rf_waddr_o}, {1'b1, 5'd3});
    end

    // reset mid-contention discards the starvation history
    drive_pipe(1'b1, 5'd4, 32'h00000044);
    drive_lu(1'b1, 5'd10, 32'h000000AA);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    #1;
    check("midreset_rf", {rf_we_o, rf_waddr_o, rf_wdata_o}, 38'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("midreset_stall", 38'(stall_o), 38'(i == 4));
      step();
    end
    drive_lu(1'b0, 5'd0, 32'd0);
    step();

    // randomized traffic obeying both producers' hold rules
    for (int i = 0; i < 400; i++) begin
      if (!prev_stall) begin
        drive_pipe(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom);
      end
      if (!prev_lu_pending) begin
        drive_lu(($urandom_range(0, 9) < 5), 5'($urandom_range(0, 31)), $urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
